shift_add_mult: RTL and testbench
=================================

# shift_add_mult

Iterative shift-and-add unsigned multiplier controller. It sequences a single shared carry-lookahead adder over WIDTH cycles to produce a 2·WIDTH-bit product. Valid/ready handshakes are used on both the operand and result sides. It is the first sequential consumer of the CLA adders and the baseline against which the combinational array multipliers are compared.

## Interface
- WIDTH, 4, operand width in bits; must be a multiple of 4 and ≥ 4.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a/b present.
- in_ready  out  1  block can accept operands; high only in IDLE and while rst is low.
- a  in  WIDTH  multiplicand, unsigned.
- b  in  WIDTH  multiplier, unsigned.
- out_valid  out  1  product valid; held until accepted.
- out_ready  in  1  consumer accepts product.
- product  out  2·WIDTH  a·b, unsigned.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE**
  - in_ready=1.
  - On a rising edge with in_valid&&in_ready: latch mcand←a, P←{1'b0, WIDTH'b0, b}, count←0, then go to RUN.
  - a/b are ignored at all other times.
- **RUN**
  - The shared adder is driven with P[2W-1:W], mcand, cin=0, and produces a WIDTH+1-bit sum.
  - Each edge: if P[0]=1, P←{sum, P[W-1:1]}; else P←{1'b0, P[2W-1:1]}.
  - count←count+1.
  - When count reaches WIDTH−1 on an edge, go to DONE.
  - P is 2·WIDTH+1 bits. The carry out occupies the top bit before each shift and is never lost.
- **DONE**
  - out_valid=1 and product=P[2W-1:0].
  - On an edge with out_ready=1: go to IDLE and clear out_valid. product holds its last value until the next DONE.
- No IDLE bypass: in_ready stays 0 in DONE even when out_ready=1 in the same cycle. The minimum issue interval is WIDTH+2 cycles.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- **Reset values:** state=IDLE, out_valid=0, product=0, busy=0, count=0, P=0. in_ready=0 while rst=1, and 1 on the first cycle after rst deasserts.
- **Reset mid-operation** (RUN or DONE): the operation is abandoned with no output. The block is in IDLE on the next cycle.
- **Arithmetic:**
  - Result is exact for all operand pairs. The maximum is (2^W−1)², which fits 2·WIDTH bits.
  - Zero operands take the full WIDTH cycles; no early termination.

## Timing
- Accept edge E (in_valid&&in_ready sampled high).
- RUN spans edges E+1 … E+WIDTH.
- out_valid is high after edge E+WIDTH. Latency is WIDTH cycles from accept to out_valid.
- out_valid falls after the first edge at which out_ready=1.
- in_ready rises in the cycle after that edge.
- For WIDTH=4 with out_ready tied high: accept at edge 0, out_valid during cycle 4, next accept at edge 6.

## Structure
- **Shared package/header mult_defs:**
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Count width $clog2(WIDTH).
  - These are reused by the planned Booth and array-multiplier wrappers.
- **Sub-module add_unit #(WIDTH):** (a, b, cin, sum[WIDTH:0]). It chains WIDTH/4 cla4x4 instances with carry ripple between slices. It is the only arithmetic in the block.
- The controller contains only the FSM, count, and the P/mcand registers.

## Test plan
- **Max operands, WIDTH=4:** a=15, b=15, out_ready=1 → out_valid rises 4 cycles after accept; product=225 (0xE1); in_ready returns 2 cycles after accept+4.
- **Zero operand:** a=0, b=9 → product=0 after exactly 4 cycles. Then a=9, b=0 → product=0.
- **Backpressure:** a=7, b=6, out_ready held low 5 cycles after out_valid → product=42 stable throughout, in_ready=0, busy=1. A new in_valid with a=3, b=3 during this window is ignored.
- **Mid-operation reset:** rst pulsed 1 cycle during the 2nd RUN cycle of a=13, b=11 → no out_valid; in_ready=1 the cycle after rst falls. A following a=13, b=11 gives 143.
- **Back-to-back and exhaustive:** all 256 a/b pairs back-to-back with random out_ready stalls → every product matches a·b, no duplicated or dropped results.
- **WIDTH=8:** a=255, b=255 → product=65025 after 8 cycles.

Source files
------------

// File: rtl/mult_defs_pkg.sv
// Shared multiplier definitions: FSM encodings and counter sizing, reused by
// the shift-add, Booth and array multiplier wrappers.
package mult_defs;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/add_unit.sv
// WIDTH-bit adder built from 4-bit carry-lookahead slices with ripple
// between slices; the only arithmetic in the multiplier.
module cla4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c;
    end
endmodule

module add_unit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   sum
);
    localparam int SLICES = WIDTH / 4;

    logic [SLICES:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICES; i++) begin : g_slice
        cla4x4 u_cla (
            .a    (a[4*i +: 4]),
            .b    (b[4*i +: 4]),
            .cin  (c[i]),
            .sum  (sum[4*i +: 4]),
            .cout (c[i+1])
        );
    end

    assign sum[WIDTH] = c[SLICES];
endmodule

// File: rtl/shift_add_mult.sv
// Iterative unsigned shift-and-add multiplier: one shared adder, WIDTH RUN
// cycles per product, valid/ready on operands and result.
module shift_add_mult
    import mult_defs::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int CW = cnt_w(WIDTH);

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic [2*WIDTH:0]   p;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   p_step;

    add_unit #(.WIDTH(WIDTH)) u_add (
        .a   (p[2*WIDTH-1:WIDTH]),
        .b   (mcand),
        .cin (1'b0),
        .sum (sum)
    );

    // Carry out of the add lands in the upper half after the shift, so the
    // extra top bit of P never holds anything but zero.
    always_comb begin
        p_step = p[0] ? {1'b0, sum, p[WIDTH-1:1]} : {1'b0, p[2*WIDTH:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            p       <= '0;
            mcand   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= a;
                        p     <= {1'b0, {WIDTH{1'b0}}, b};
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    p     <= p_step;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        product <= p_step[2*WIDTH-1:0];
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);
endmodule

// File: tb/tb_shift_add_mult.sv
// Bench for shift_add_mult: cycle model plus result scoreboard for WIDTH=4,
// directed literal checks, and a WIDTH=8 corner case.
module tb_shift_add_mult;
    localparam int W  = 4;
    localparam int W8 = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             in_valid, in_ready, out_valid, busy;
    logic [W-1:0]     a, b;
    logic [2*W-1:0]   product;
    wire              out_ready;
    logic             or_val, rnd_mode, rnd_bit;

    logic             in_valid8, in_ready8, out_valid8, busy8, out_ready8;
    logic [W8-1:0]    a8, b8;
    logic [2*W8-1:0]  product8;

    assign out_ready = rnd_mode ? rnd_bit : or_val;

    shift_add_mult #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    shift_add_mult #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .product(product8), .busy(busy8)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_res = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1 rnd_bit = ($urandom_range(0, 3) != 0);
    end

    // Behavioural model: idle / counting down W cycles / holding a result.
    bit             m_idle = 1;
    int             m_left = 0;
    bit             m_done = 0;
    logic [2*W-1:0] m_prod = '0;
    logic [2*W-1:0] m_pend = '0;
    longint         q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_idle = 1; m_left = 0; m_done = 0; m_prod = '0;
            q.delete();
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle = 0;
                m_left = W;
                m_pend = a * b;
                q.push_back(longint'(m_pend));
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1;
                m_prod = m_pend;
            end
        end else if (out_ready) begin
            m_done = 0;
            m_idle = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, m_idle && !rst);
            chk("out_valid", out_valid, m_done);
            chk("busy", busy, !m_idle);
            chk("product", product, m_prod);
            if (out_valid && out_ready && !rst) begin
                chk("sb_depth", q.size(), 1);
                if (q.size() != 0) begin
                    chk("sb_product", product, q.pop_front());
                    n_res++;
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib);
        int t;
        t = 0;
        in_valid = 1; a = ia; b = ib;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    // Counts edges from the accept edge until out_valid; returns at a falling edge.
    task automatic wait_valid(output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) chk("valid_timeout", out_valid, 1);
    endtask

    initial begin
        int lat;
        int base;
        int t;
        rst = 1; in_valid = 0; a = '0; b = '0;
        or_val = 1; rnd_mode = 0;
        in_valid8 = 0; a8 = '0; b8 = '0; out_ready8 = 1;

        repeat (2) @(posedge clk);
        #1 chk_en = 1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_product", product, 0);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("first_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Max operands
        issue(4'd15, 4'd15);
        wait_valid(lat);
        chk("max_latency", lat, 4);
        chk("max_product", product, 225);
        @(posedge clk);
        @(negedge clk);
        chk("max_in_ready_back", in_ready, 1);
        @(posedge clk); #1;

        // Zero operands
        issue(4'd0, 4'd9);
        wait_valid(lat);
        chk("zero_a_latency", lat, 4);
        chk("zero_a_product", product, 0);
        @(posedge clk); #1;
        issue(4'd9, 4'd0);
        wait_valid(lat);
        chk("zero_b_latency", lat, 4);
        chk("zero_b_product", product, 0);
        @(posedge clk); #1;

        // Backpressure with an ignored in_valid in DONE
        or_val = 0;
        issue(4'd7, 4'd6);
        wait_valid(lat);
        chk("bp_product", product, 42);
        @(posedge clk);
        #1 in_valid = 1; a = 4'd3; b = 4'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_product", product, 42);
            chk("bp_hold_in_ready", in_ready, 0);
            chk("bp_hold_busy", busy, 1);
            @(posedge clk); #1;
        end
        in_valid = 0; or_val = 1;
        @(negedge clk);
        chk("bp_still_valid", out_valid, 1);
        @(posedge clk);
        @(negedge clk);
        chk("bp_released", out_valid, 0);
        chk("bp_product_kept", product, 42);
        @(posedge clk); #1;

        // Reset during the second RUN cycle
        issue(4'd13, 4'd11);
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mid_rst_no_output", out_valid, 0);
        end
        @(posedge clk); #1;
        issue(4'd13, 4'd11);
        wait_valid(lat);
        chk("after_rst_latency", lat, 4);
        chk("after_rst_product", product, 143);
        @(posedge clk); #1;

        // Exhaustive back-to-back with random result stalls
        base = n_res;
        rnd_mode = 1;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                issue(W'(i), W'(j));
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        rnd_mode = 0;
        chk("exh_results", n_res - base, 256);
        chk("exh_leftover", q.size(), 0);
        @(posedge clk); #1;

        // WIDTH=8 maximum
        @(negedge clk);
        chk("w8_in_ready", in_ready8, 1);
        @(posedge clk);
        #1 in_valid8 = 1; a8 = 8'd255; b8 = 8'd255;
        @(posedge clk);
        #1 in_valid8 = 0;
        lat = 0;
        @(negedge clk);
        while (!out_valid8 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("w8_latency", lat, 8);
        chk("w8_product", product8, 65025);
        @(posedge clk);
        @(negedge clk);
        chk("w8_released", out_valid8, 0);
        chk("w8_in_ready_back", in_ready8, 1);

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
